// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps one imem request outstanding at most,
// and buffers returned words in a 2-entry prefetch queue that feeds the IF/ID register.

module fetch_unit_chk (
  input logic       clk,
  input logic       rst,
  input logic       push,
  input logic [1:0] count
);

  // the space rule keeps a pushed word from ever landing on a full queue
  a_no_push_on_full: assert property (@(posedge clk) disable iff (rst) push |-> (count != 2'd2));
  a_count_range:     assert property (@(posedge clk) disable iff (rst) count <= 2'd2);

endmodule

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ins_out,
  output logic [31:0] pc_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t      state_r, state_n_s;
  logic [31:0] fetch_pc_r, fetch_pc_n_s;
  logic        req_r, req_n_s;
  logic [31:0] addr_r, addr_n_s;
  logic [1:0]  count_r, count_n_s;
  logic [31:0] q0_pc_r, q0_ins_r, q1_pc_r, q1_ins_r;
  logic [31:0] q0_pc_n_s, q0_ins_n_s, q1_pc_n_s, q1_ins_n_s;
  logic        pop_s, push_s, wr0_s, wr1_s;
  logic [1:0]  count_pop_s, count_after_s;

  function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

  assign valid_out     = (count_r != 2'd0);
  assign pop_s         = valid_out && !stall && !redirect;
  assign push_s        = (state_r == ST_WAIT) && imem_ack && !redirect;
  assign count_pop_s   = count_r - {1'b0, pop_s};
  assign count_after_s = count_pop_s + {1'b0, push_s};

  assign imem_req  = req_r;
  assign imem_addr = addr_r;
  assign ins_out   = valid_out ? q0_ins_r : 32'd0;
  assign pc_out    = valid_out ? q0_pc_r  : 32'd0;

  // slot 0 is always the head; a push lands in the first slot free after this cycle's pop
  assign wr0_s      = push_s && (count_pop_s == 2'd0);
  assign wr1_s      = push_s && (count_pop_s != 2'd0);
  assign q0_pc_n_s  = wr0_s ? addr_r     : (pop_s ? q1_pc_r  : q0_pc_r);
  assign q0_ins_n_s = wr0_s ? imem_rdata : (pop_s ? q1_ins_r : q0_ins_r);
  assign q1_pc_n_s  = wr1_s ? addr_r     : q1_pc_r;
  assign q1_ins_n_s = wr1_s ? imem_rdata : q1_ins_r;
  assign count_n_s  = redirect ? 2'd0 : count_after_s;

  // next state, fetch PC and request decode
  always_comb begin
    state_n_s    = state_r;
    fetch_pc_n_s = fetch_pc_r;
    req_n_s      = req_r;
    addr_n_s     = addr_r;
    case (state_r)
      ST_IDLE: begin
        if (redirect) begin
          fetch_pc_n_s = redirect_pc;
          req_n_s      = 1'b0;
        end else if (count_pop_s < 2'd2) begin
          state_n_s = ST_WAIT;
          req_n_s   = 1'b1;
          addr_n_s  = fetch_pc_r;
        end else begin
          req_n_s = 1'b0;
        end
      end
      ST_WAIT: begin
        if (imem_ack && redirect) begin
          fetch_pc_n_s = redirect_pc;
          state_n_s    = ST_IDLE;
          req_n_s      = 1'b0;
        end else if (imem_ack) begin
          fetch_pc_n_s = next_word_addr(addr_r);
          if (count_after_s < 2'd2) begin
            addr_n_s = next_word_addr(addr_r);
          end else begin
            state_n_s = ST_IDLE;
            req_n_s   = 1'b0;
          end
        end else if (redirect) begin
          // the request cannot be retracted, so its late response must be swallowed
          fetch_pc_n_s = redirect_pc;
          state_n_s    = ST_DROP;
        end else begin
          req_n_s = 1'b1;
        end
      end
      ST_DROP: begin
        if (redirect) begin
          fetch_pc_n_s = redirect_pc;
        end else begin
          fetch_pc_n_s = fetch_pc_r;
        end
        if (imem_ack) begin
          state_n_s = ST_IDLE;
          req_n_s   = 1'b0;
        end else begin
          req_n_s = 1'b1;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
        req_n_s   = 1'b0;
      end
    endcase
  end

  // state, request and queue registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      fetch_pc_r <= RESET_PC;
      req_r      <= 1'b0;
      addr_r     <= 32'd0;
      count_r    <= 2'd0;
      q0_pc_r    <= 32'd0;
      q0_ins_r   <= 32'd0;
      q1_pc_r    <= 32'd0;
      q1_ins_r   <= 32'd0;
    end else begin
      state_r    <= state_n_s;
      fetch_pc_r <= fetch_pc_n_s;
      req_r      <= req_n_s;
      addr_r     <= addr_n_s;
      count_r    <= count_n_s;
      q0_pc_r    <= q0_pc_n_s;
      q0_ins_r   <= q0_ins_n_s;
      q1_pc_r    <= q1_pc_n_s;
      q1_ins_r   <= q1_ins_n_s;
    end
  end

  fetch_unit_chk u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .count (count_r)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected {pc, ins} pairs are queued by the stimulus and
// popped by a monitor whenever the DUT hands an instruction downstream.

module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] ins_out;
  logic [31:0] pc_out;
  logic        valid_out;

  logic        req2;
  logic [31:0] addr2;
  logic        ack2;
  logic [31:0] rdata2;
  logic [31:0] ins2;
  logic [31:0] pc2;
  logic        valid2;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_wait = 0;
  int wait_cnt = 0;
  logic [31:0] exp_q[$];

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ins_out     (ins_out),
    .pc_out      (pc_out),
    .valid_out   (valid_out)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (req2),
    .imem_addr   (addr2),
    .imem_ack    (ack2),
    .imem_rdata  (rdata2),
    .stall       (1'b0),
    .redirect    (1'b0),
    .redirect_pc (32'h0000_0000),
    .ins_out     (ins2),
    .pc_out      (pc2),
    .valid_out   (valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory: word = addr ^ 0xA5A5, ack after mem_wait cycles of a pending request
  assign imem_rdata = imem_addr ^ 32'h0000_A5A5;
  assign imem_ack   = imem_req && (wait_cnt >= mem_wait);
  assign rdata2     = addr2 ^ 32'h0000_A5A5;
  assign ack2       = req2;

  always @(posedge clk) begin
    if (!imem_req || imem_ack) wait_cnt <= 0;
    else                       wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_imem_req"},  {31'd0, imem_req},  32'd0);
    chk({tag, "_imem_addr"}, imem_addr,          32'd0);
    chk({tag, "_valid_out"}, {31'd0, valid_out}, 32'd0);
    chk({tag, "_ins_out"},   ins_out,            32'd0);
    chk({tag, "_pc_out"},    pc_out,             32'd0);
  endtask

  // monitor: compare the head each time it is consumed downstream
  always @(negedge clk) begin
    if (!rst && valid_out && !stall && !redirect) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: pc_out=%h with empty scoreboard at %0t", pc_out, $time);
      end else begin
        logic [31:0] exp_pc;
        exp_pc = exp_q.pop_front();
        chk("sb_pc_out", pc_out, exp_pc);
        chk("sb_ins_out", ins_out, exp_pc ^ 32'h0000_A5A5);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; mem_wait = 0;
    repeat (2) tick();
    chk_reset_outputs("init");

    // stall for 6 cycles from reset release: two words buffered, then request drops
    stall = 1'b1;
    push_exp(32'h0000_0100, 8);
    rst = 1'b0;
    tick(); samp();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0000_0100);
    chk("first_valid", {31'd0, valid_out}, 32'd0);
    repeat (2) tick();
    samp();
    chk("full_req", {31'd0, imem_req}, 32'd0);
    chk("full_valid", {31'd0, valid_out}, 32'd1);
    chk("full_head", pc_out, 32'h0000_0100);
    repeat (3) tick();
    stall = 1'b0;
    samp();
    chk("stalled_req", {31'd0, imem_req}, 32'd0);
    chk("stalled_head", pc_out, 32'h0000_0100);
    tick(); samp();
    chk("resume_req", {31'd0, imem_req}, 32'd1);
    chk("resume_addr", imem_addr, 32'h0000_0108);
    chk("resume_valid", {31'd0, valid_out}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick(); samp();
      chk("stream_valid", {31'd0, valid_out}, 32'd1);
    end

    // asynchronous reset in the middle of a WAIT with a buffered word
    tick();
    rst = 1'b1;
    #1;
    chk_reset_outputs("async");

    // redirect while a slow request is pending: late word is dropped
    mem_wait = 3;
    push_exp(32'h0000_0400, 1);
    tick();
    rst = 1'b0;
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0400;
    samp();
    chk("slow_req", {31'd0, imem_req}, 32'd1);
    tick();
    redirect = 1'b0;
    samp();
    chk("drop_req_held", {31'd0, imem_req}, 32'd1);
    chk("drop_addr_held", imem_addr, 32'h0000_0100);
    chk("drop_valid", {31'd0, valid_out}, 32'd0);
    repeat (2) begin
      tick(); samp();
      chk("drop_valid", {31'd0, valid_out}, 32'd0);
    end
    tick(); samp();
    chk("drop_done_req", {31'd0, imem_req}, 32'd0);
    chk("drop_done_valid", {31'd0, valid_out}, 32'd0);
    tick(); samp();
    chk("redir_req", {31'd0, imem_req}, 32'd1);
    chk("redir_addr", imem_addr, 32'h0000_0400);
    repeat (4) begin
      chk("redir_wait_valid", {31'd0, valid_out}, 32'd0);
      tick(); samp();
    end
    chk("redir_word_valid", {31'd0, valid_out}, 32'd1);
    tick(); samp();
    chk("after_redir_valid", {31'd0, valid_out}, 32'd0);
    tick();
    rst = 1'b1;
    mem_wait = 0;

    // redirect in the same cycle as the ack, plus wrap-around on the second instance
    push_exp(32'h0000_0800, 2);
    tick();
    rst = 1'b0;
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0800;
    samp();
    chk("ack_redir_addr", imem_addr, 32'h0000_0100);
    tick();
    redirect = 1'b0;
    samp();
    chk("ack_redir_req", {31'd0, imem_req}, 32'd0);
    chk("ack_redir_valid", {31'd0, valid_out}, 32'd0);
    chk("wrap_pc0", pc2, 32'hFFFF_FFFC);
    chk("wrap_ins0", ins2, 32'hFFFF_5A59);
    tick(); samp();
    chk("ack_redir_req2", {31'd0, imem_req}, 32'd1);
    chk("ack_redir_addr2", imem_addr, 32'h0000_0800);
    chk("ack_redir_valid2", {31'd0, valid_out}, 32'd0);
    chk("wrap_pc1", pc2, 32'h0000_0000);
    chk("wrap_ins1", ins2, 32'h0000_A5A5);
    chk("wrap_valid1", {31'd0, valid2}, 32'd1);
    tick(); samp();
    chk("ack_redir_out", {31'd0, valid_out}, 32'd1);
    tick(); samp();
    chk("ack_redir_out2", {31'd0, valid_out}, 32'd1);
    tick();
    rst = 1'b1;
    #1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
